// File: rtl/mem_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between instruction fetch (I)
//             and data access (D). One access in flight at a time, fixed
//             memory latency, D priority bounded by a starvation streak
//             limit, unaligned word accesses trapped and flagged on err.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 16,
  parameter int MEM_LAT    = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic [DW-1:0] if_rdata_o,
  output logic          if_done_o,
  input  logic          d_req_i,
  input  logic          d_wr_i,
  input  logic [AW-1:0] d_addr_i,
  input  logic [DW-1:0] d_wdata_i,
  output logic [DW-1:0] d_rdata_o,
  output logic          d_done_o,
  output logic          mem_en_o,
  output logic          mem_wr_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i,
  output logic          err_o,
  output logic          busy_o
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          port_d_q, port_d_d;     // 1 = access belongs to D port
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          if_done_q, if_done_d;
  logic          d_done_q, d_done_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_wr_q, mem_wr_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          err_q, err_d;
  logic          busy_q, busy_d;

  logic          w_d_win;
  logic          w_i_win;
  logic [AW-1:0] w_addr;

  // Arbitration decision: D wins unless I has waited through a full streak.
  always_comb begin
    w_d_win = d_req_i && !(if_req_i && (streak_q == SW'(STARVE_MAX)));
    w_i_win = !w_d_win && if_req_i;
    w_addr  = w_d_win ? d_addr_i : if_addr_i;
  end

  // Next-state logic for the access sequencer and all registered outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    streak_d    = streak_q;
    port_d_d    = port_d_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_done_d   = 1'b0;
    d_done_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_wr_d    = mem_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    err_d       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Streak only counts D grants that actually held off a pending fetch.
        if (w_i_win || !if_req_i) begin
          streak_d = '0;
        end else if (w_d_win && (streak_q != SW'(STARVE_MAX))) begin
          streak_d = streak_q + SW'(1);
        end
        if (w_d_win || w_i_win) begin
          port_d_d = w_d_win;
          if (w_addr[0]) begin
            // Unaligned: answer straight away, memory is never touched.
            state_d   = S_RESP;
            err_d     = 1'b1;
            d_done_d  = w_d_win;
            if_done_d = w_i_win;
          end else begin
            state_d     = S_ISSUE;
            mem_en_d    = 1'b1;
            mem_wr_d    = w_d_win && d_wr_i;
            mem_addr_d  = w_addr;
            mem_wdata_d = w_d_win ? d_wdata_i : '0;
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = CW'(MEM_LAT - 1);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_RESP;
          if (port_d_q) begin
            d_done_d = 1'b1;
            if (!mem_wr_q) begin
              d_rdata_d = mem_rdata_i;
            end
          end else begin
            if_done_d  = 1'b1;
            if_rdata_d = mem_rdata_i;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      streak_q    <= '0;
      port_d_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      streak_q    <= streak_d;
      port_d_q    <= port_d_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_done_q   <= if_done_d;
      d_done_q    <= d_done_d;
      mem_en_q    <= mem_en_d;
      mem_wr_q    <= mem_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign d_rdata_o   = d_rdata_q;
  assign d_done_o    = d_done_q;
  assign mem_en_o    = mem_en_q;
  assign mem_wr_o    = mem_wr_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign err_o       = err_q;
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
